axi_burst_addr_gen: RTL

Sequential AXI4 burst address generator: accepts one AW/AR command (addr, burst, size, len, id) over a valid/ready handshake and emits one beat descriptor per data beat (address, byte lanes, beat index, last) over a second valid/ready handshake. Sits between the slave-side AW/AR channel and the memory/register back-end of our AXI adapters. Supports FIXED, INCR and WRAP bursts, full 8-bit AXI4 lengths, narrow transfers and back-to-back commands without bubbles.

---
 rtl/axi_burst_pkg.sv | 27 ++
 rtl/axi_beat_next.sv | 45 ++++
 rtl/axi_burst_addr_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/axi_burst_pkg.sv
// Shared types and mask helpers for the AXI burst address generator.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    FIXED    = 2'd0,
    INCR     = 2'd1,
    WRAP     = 2'd2,
    RESERVED = 2'd3
  } burst_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Wide enough for any supported address width; callers truncate to ADDR_WIDTH.
  localparam int MASK_W = 64;

  function automatic logic [MASK_W-1:0] align_mask(input logic [2:0] size);
    return ~((MASK_W'(1) << size) - MASK_W'(1));
  endfunction

  function automatic logic [MASK_W-1:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    return ((MASK_W'(len) + MASK_W'(1)) << size) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/axi_beat_next.sv
// Combinational beat address step and byte-lane calculation.
// With i_advance low the input address passes through, so the same logic yields lanes for a burst's first beat.
module axi_beat_next
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_SIZE  = 2,
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic                  i_advance,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  burst_e                i_burst,
  input  logic [2:0]            i_size,
  input  logic [7:0]            i_len,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_SIZE-1:0]  o_lower,
  output logic [DATA_SIZE-1:0]  o_upper
);

  localparam logic [ADDR_WIDTH-1:0] LANE_BITS = ADDR_WIDTH'((1 << DATA_SIZE) - 1);

  logic [ADDR_WIDTH-1:0] w_nBytes;
  logic [ADDR_WIDTH-1:0] w_alignMask;
  logic [ADDR_WIDTH-1:0] w_wrapMask;
  logic [ADDR_WIDTH-1:0] w_sum;
  logic [ADDR_WIDTH-1:0] w_stepAddr;

  always_comb begin
    w_nBytes    = ADDR_WIDTH'(1) << i_size;
    w_alignMask = ADDR_WIDTH'(align_mask(i_size));
    w_wrapMask  = ADDR_WIDTH'(wrap_mask(i_len, i_size));
    w_sum       = i_addr + w_nBytes;
    case (i_burst)
      // Alignment only touches lane-select bits, so oversized beats keep their upper offset.
      INCR:    w_stepAddr = ALIGN_ADDR ? (w_sum & (w_alignMask | ~LANE_BITS)) : w_sum;
      WRAP:    w_stepAddr = (i_addr & ~w_wrapMask) | (w_sum & w_wrapMask);
      default: w_stepAddr = i_addr;
    endcase
    o_addr  = i_advance ? w_stepAddr : i_addr;
    o_lower = o_addr[DATA_SIZE-1:0];
    o_upper = (o_addr[DATA_SIZE-1:0] & w_alignMask[DATA_SIZE-1:0])
              + w_nBytes[DATA_SIZE-1:0] - DATA_SIZE'(1);
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address generator: one AW/AR command in, one beat descriptor per data beat out.
// Optional command legality checker enabled by defining AXI_BURST_ADDR_ERR_CHECK_EN.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter bit ALIGN_ADDR = 1'b1,
  localparam int DATA_SIZE = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [DATA_SIZE-1:0]  beat_lower,
  output logic [DATA_SIZE-1:0]  beat_upper,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic                  cmd_err
);

  state_e                r_state, w_nextState;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_SIZE-1:0]  r_lower, r_upper;
  burst_e                r_burst;
  logic [2:0]            r_size;
  logic [7:0]            r_len, r_idx;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_last;

  logic                  w_beatFire, w_cmdReady, w_load, w_step;
  burst_e                w_srcBurst;
  logic [ADDR_WIDTH-1:0] w_srcAddr, w_nextAddr;
  logic [2:0]            w_srcSize;
  logic [7:0]            w_srcLen;
  logic [DATA_SIZE-1:0]  w_nextLower, w_nextUpper;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A new command may only enter on the last beat handshake, which removes the bubble between bursts.
  always_comb begin
    w_nextState = r_state;
    w_cmdReady  = 1'b0;
    w_beatFire  = (r_state == BURST) && beat_ready;
    if (!rst) w_cmdReady = (r_state == IDLE) || (w_beatFire && r_last);
    w_load = cmd_valid && w_cmdReady;
    w_step = w_beatFire && !r_last;
    if (w_load)                  w_nextState = BURST;
    else if (w_beatFire && r_last) w_nextState = IDLE;
  end

  assign w_srcAddr  = w_load ? cmd_addr : r_addr;
  assign w_srcBurst = w_load ? burst_e'(cmd_burst) : r_burst;
  assign w_srcSize  = w_load ? cmd_size : r_size;
  assign w_srcLen   = w_load ? cmd_len : r_len;

  axi_beat_next #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_SIZE (DATA_SIZE),
    .ALIGN_ADDR(ALIGN_ADDR)
  ) u_next (
    .i_advance(!w_load),
    .i_addr   (w_srcAddr),
    .i_burst  (w_srcBurst),
    .i_size   (w_srcSize),
    .i_len    (w_srcLen),
    .o_addr   (w_nextAddr),
    .o_lower  (w_nextLower),
    .o_upper  (w_nextUpper)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_lower <= '0;
      r_upper <= '0;
      r_burst <= FIXED;
      r_size  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_id    <= '0;
      r_last  <= 1'b0;
    end else if (w_load || w_step) begin
      r_addr  <= w_nextAddr;
      r_lower <= w_nextLower;
      r_upper <= w_nextUpper;
      if (w_load) begin
        r_burst <= burst_e'(cmd_burst);
        r_size  <= cmd_size;
        r_len   <= cmd_len;
        r_id    <= cmd_id;
        r_idx   <= '0;
        r_last  <= (cmd_len == 8'd0);
      end else begin
        r_idx  <= r_idx + 8'd1;
        r_last <= ((r_idx + 8'd1) == r_len);
      end
    end
  end

  assign cmd_ready  = w_cmdReady;
  assign beat_valid = (r_state == BURST);
  assign beat_addr  = r_addr;
  assign beat_lower = r_lower;
  assign beat_upper = r_upper;
  assign beat_idx   = r_idx;
  assign beat_last  = r_last;
  assign beat_id    = r_id;

`ifdef AXI_BURST_ADDR_ERR_CHECK_EN
  logic [ADDR_WIDTH-1:0] w_cmdAlignMask;
  logic [16:0]           w_pageEnd;
  logic                  w_illegal;
  logic                  r_err;

  // The page check measures the span the beats actually cover, from the aligned start when aligning.
  always_comb begin
    w_cmdAlignMask = ADDR_WIDTH'(align_mask(cmd_size));
    w_pageEnd = 17'(cmd_addr[11:0] & (ALIGN_ADDR ? w_cmdAlignMask[11:0] : 12'hFFF))
                + ((17'(cmd_len) + 17'd1) << cmd_size);
    w_illegal = 1'b0;
    case (burst_e'(cmd_burst))
      RESERVED: w_illegal = 1'b1;
      WRAP:     w_illegal = !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})
                            || ((cmd_addr & ~w_cmdAlignMask) != '0);
      INCR:     w_illegal = (w_pageEnd > 17'h1000);
      default:  w_illegal = 1'b0;
    endcase
    if ({29'd0, cmd_size} > 32'(DATA_SIZE)) w_illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_load && w_illegal;
  end

  assign cmd_err = r_err;
`else
  assign cmd_err = 1'b0;
`endif

endmodule
